// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// datapath widths and a small address alignment helper.
package instr_fetch_pkg;

    localparam int ADDR_W  = 32;
    localparam int INSTR_W = 32;
    localparam int CNT_W   = 7;

    // IDLE: one cycle after reset, FETCH: normal operation,
    // DROP: waiting out a request whose result is no longer wanted.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DROP  = 2'd2
    } fetch_state_t;

    // Force an address onto a 4-byte boundary.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues word-aligned fetches to instruction memory,
// delivers one instruction per cycle into a registered output stage, and
// handles stalls and branch/jump redirects (flushing wrong-path fetches).
//
// Handshakes:
//   imem_req/imem_ack : imem_req stays high with a stable imem_addr until a
//                       one-cycle imem_ack arrives; imem_rdata is valid with ack.
//   out_valid/stall   : an instruction transfers downstream on every cycle with
//                       out_valid=1 and stall=0; while stalled the output stage
//                       holds and no new request is issued.
//
// Optional build macro IFETCH_STALL_CNT_EN adds a saturating stall_cycles
// counter output.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_ack,
    input  logic [INSTR_W-1:0]  imem_rdata,
    input  logic                stall,
    input  logic                redirect,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic                out_valid,
    output logic [ADDR_W-1:0]   out_pc,
    output logic [INSTR_W-1:0]  out_instr,
`ifdef IFETCH_STALL_CNT_EN
    output logic [15:0]         stall_cycles,
`endif
    output logic [CNT_W-1:0]    out_total
);

    fetch_state_t        state;
    logic [ADDR_W-1:0]   pc;
    logic [ADDR_W-1:0]   drop_addr;
    logic [CNT_W-1:0]    count;

    // Running count is the same value that out_total reports.
    assign out_total = count;

    // Memory request: suppressed while the output stage is held by a stall;
    // in DROP the abandoned request must be completed at its original address.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc;
        case (state)
            ST_FETCH: begin
                imem_req  = !out_valid || !stall;
                imem_addr = pc;
            end
            ST_DROP: begin
                imem_req  = 1'b1;
                imem_addr = drop_addr;
            end
            default: begin
                imem_req  = 1'b0;
                imem_addr = pc;
            end
        endcase
    end

    // Fetch FSM together with the pc, count and registered output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            pc        <= RESET_PC;
            count     <= '0;
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_instr <= '0;
            drop_addr <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state <= ST_FETCH;
                    if (redirect) begin
                        out_valid <= 1'b0;
                        pc        <= word_align(redirect_pc);
                    end
                end

                ST_FETCH: begin
                    if (redirect) begin
                        // Flush; a request still in flight must be drained in DROP.
                        out_valid <= 1'b0;
                        pc        <= word_align(redirect_pc);
                        if (imem_req && !imem_ack) begin
                            state     <= ST_DROP;
                            drop_addr <= pc;
                        end
                    end else if (imem_req && imem_ack) begin
                        out_instr <= imem_rdata;
                        out_pc    <= pc + 32'd4;
                        count     <= count + 7'd1;
                        out_valid <= 1'b1;
                        pc        <= pc + 32'd4;
                    end else if (out_valid && !stall) begin
                        out_valid <= 1'b0;
                    end
                end

                ST_DROP: begin
                    if (redirect) begin
                        out_valid <= 1'b0;
                        pc        <= word_align(redirect_pc);
                    end
                    // The late response is discarded; resume at the current pc.
                    if (imem_ack) begin
                        state <= ST_FETCH;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef IFETCH_STALL_CNT_EN
    // Saturating count of cycles where a valid instruction is held by stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (out_valid && stall && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 imem_req  out  1  instruction-memory request; held high until imem_ack.
REQ-005 imem_addr  out  32  word-aligned fetch address, stable while imem_req high.
REQ-006 imem_ack  in  1  one-cycle acknowledge; imem_rdata valid in same cycle.
REQ-007 imem_rdata  in  32  fetched instruction.
REQ-008 stall  in  1  downstream (IF/ID) cannot accept this cycle.
REQ-009 redirect  in  1  one-cycle branch/jump taken pulse.
REQ-010 redirect_pc  in  32  target address qualified by redirect.
REQ-011 out_valid  out  1  out_pc/out_instr/out_total hold a valid instruction.
REQ-012 out_pc  out  32  fetch address + 4 of delivered instruction.
REQ-013 out_instr  out  32  delivered instruction word.
REQ-014 out_total  out  7  running count of delivered instructions, including this one.

Function
REQ-015 Registered outputs; transfer to downstream occurs on any cycle with out_valid=1 and stall=0.
REQ-016 FSM states: IDLE, FETCH, DROP; reset enters IDLE; IDLE -> FETCH unconditionally next cycle, imem_req=0 in IDLE.
REQ-017 FETCH: imem_req = (!out_valid || !stall), imem_addr = pc register.
REQ-018 FETCH, imem_ack, no redirect: out_instr<=imem_rdata, out_pc<=pc+4, out_total<=count+1, count<=count+1, out_valid<=1, pc<=pc+4; one instruction per cycle sustained with single-cycle ack.
REQ-019 out_valid=1, stall=0, no ack in same cycle: out_valid<=0.
REQ-020 out_valid=1, stall=1: all out_* and pc hold; no new request issued.
REQ-021 redirect in any state: out_valid<=0 (flush), pc<={redirect_pc[31:2],2'b00}; redirect has priority over stall and ack.
REQ-022 redirect in FETCH with imem_req=1 and imem_ack=0: move to DROP, latch current address in drop_addr.
REQ-023 redirect coincident with imem_ack: returned word discarded, count unchanged, remain FETCH.
REQ-024 DROP: imem_req=1, imem_addr=drop_addr until imem_ack; ack data discarded, count unchanged; then FETCH at updated pc.
REQ-025 redirect while in DROP: pc updated again, remain DROP.
REQ-026 count and out_total wrap 127 -> 0; pc arithmetic modulo 2^32.
REQ-027 Flushed (discarded) instructions never increment count.

Reset
REQ-028 rst: state<=IDLE, pc<=RESET_PC, count<=0, out_valid<=0, out_pc<=0, out_instr<=0, out_total<=0, drop_addr<=0.
REQ-029 rst dominates redirect, ack, stall; an outstanding imem request is abandoned (memory responder reset by same rst).

Configuration
REQ-030 Macro IFETCH_STALL_CNT_EN defined: extra output stall_cycles (16 bits) counts cycles with out_valid=1 and stall=1, saturating at 16'hFFFF, cleared by rst.
REQ-031 Macro undefined: port and counter absent; all other behaviour identical.

Structure
REQ-032 Shared package holds FSM state encoding (IDLE/FETCH/DROP), instruction/address width 32, count width 7.
REQ-033 No sub-module required; single flat module.

Verification
REQ-034 Reset with RESET_PC=0x100, single-cycle ack, stall=0 -> addrs 0x100,0x104,0x108; out_pc 0x104,0x108,0x10C; out_total 1,2,3 back-to-back.
REQ-035 stall=1 for 3 cycles with out_valid=1 -> outputs frozen, imem_req=0, no count change; release -> next fetch resumes same pc.
REQ-036 Ack latency 3, redirect to 0x203 in second wait cycle -> DROP, old address held until ack, data discarded, next imem_addr=0x200, out_total unchanged.
REQ-037 redirect coincident with ack -> out_valid=0 next cycle, returned word discarded, next imem_addr = target.
REQ-038 Deliver 130 instructions -> out_total sequence ...,127,0,1,2.
REQ-039 rst asserted mid-WAIT/DROP -> all outputs zero next cycle, IDLE, then fetch from RESET_PC.
